// File: rtl/multicycle_alu.sv
// Registered WIDTH-bit ALU for the execute stage. Single-cycle ops finish in one clock;
// shifts of 2+ positions and multiply iterate behind a start/ready/done handshake.
module multicycle_alu #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             ovf,
  output logic             take_branch
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_MUL   = 2'd2;

  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_NOT = 4'b0010,
                         OP_AND = 4'b0011, OP_OR  = 4'b0100, OP_XOR = 4'b0101,
                         OP_SRA = 4'b0110, OP_SLL = 4'b0111, OP_BEQ = 4'b1000,
                         OP_BNE = 4'b1001, OP_MUL = 4'b1010;

  logic [1:0]         state;
  logic [SHW-1:0]     cnt;
  logic               sh_left;
  logic [WIDTH-1:0]   acc;      // shift operand, or remaining multiplier bits
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;

  logic [WIDTH:0]     add_r, sub_r;
  logic [SHW-1:0]     k;
  logic [WIDTH-1:0]   sra1, sll1, sh_next;
  logic [2*WIDTH-1:0] mul_sum;
  logic [WIDTH-1:0]   c_f;
  logic               c_ovf, c_tb, is_shift, multi_shift;

  assign add_r       = {1'b0, a} + {1'b0, b};
  assign sub_r       = {1'b0, a} - {1'b0, b};
  assign k           = b[SHW-1:0];
  assign sra1        = {a[WIDTH-1], a[WIDTH-1:1]};
  assign sll1        = {a[WIDTH-2:0], 1'b0};
  assign is_shift    = (op == OP_SRA) || (op == OP_SLL);
  assign multi_shift = is_shift && (k >= SHW'(2));
  assign sh_next     = sh_left ? {acc[WIDTH-2:0], 1'b0} : {acc[WIDTH-1], acc[WIDTH-1:1]};
  assign mul_sum     = prod + (acc[0] ? mcand : '0);
  assign ready       = (state == S_IDLE);

  // Results of everything that completes in the accepting cycle; reserved ops fall into ADD.
  always_comb begin
    c_f   = add_r[WIDTH-1:0];
    c_ovf = add_r[WIDTH];
    c_tb  = 1'b0;
    case (op)
      OP_SUB: begin c_f = sub_r[WIDTH-1:0]; c_ovf = sub_r[WIDTH]; end
      OP_NOT: begin c_f = ~b;    c_ovf = 1'b0; end
      OP_AND: begin c_f = a & b; c_ovf = 1'b0; end
      OP_OR:  begin c_f = a | b; c_ovf = 1'b0; end
      OP_XOR: begin c_f = a ^ b; c_ovf = 1'b0; end
      OP_SRA: begin c_f = (k == '0) ? a : sra1; c_ovf = 1'b0; end
      OP_SLL: begin c_f = (k == '0) ? a : sll1; c_ovf = 1'b0; end
      OP_BEQ: begin c_tb = (a == b); c_f = {{(WIDTH-1){1'b0}}, c_tb}; c_ovf = 1'b0; end
      OP_BNE: begin c_tb = (a != b); c_f = {{(WIDTH-1){1'b0}}, c_tb}; c_ovf = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      sh_left     <= 1'b0;
      acc         <= '0;
      mcand       <= '0;
      prod        <= '0;
      f           <= '0;
      ovf         <= 1'b0;
      take_branch <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          // The accepting edge already performs the first step, so the counter
          // holds the number of steps still to come.
          if (op == OP_MUL) begin
            state <= S_MUL;
            prod  <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand <= {{WIDTH{1'b0}}, a} << 1;
            acc   <= b >> 1;
            cnt   <= SHW'(WIDTH-1);
          end else if (multi_shift) begin
            state   <= S_SHIFT;
            sh_left <= (op == OP_SLL);
            acc     <= (op == OP_SLL) ? sll1 : sra1;
            cnt     <= k - SHW'(1);
          end else begin
            f           <= c_f;
            ovf         <= c_ovf;
            take_branch <= c_tb;
            done        <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (cnt == SHW'(1)) begin
            f           <= sh_next;
            ovf         <= 1'b0;
            take_branch <= 1'b0;
            done        <= 1'b1;
            state       <= S_IDLE;
          end else begin
            acc <= sh_next;
          end
          cnt <= cnt - SHW'(1);
        end
        S_MUL: begin
          if (cnt == SHW'(1)) begin
            f           <= mul_sum[WIDTH-1:0];
            ovf         <= |mul_sum[2*WIDTH-1:WIDTH];
            take_branch <= 1'b0;
            done        <= 1'b1;
            state       <= S_IDLE;
          end else begin
            prod  <= mul_sum;
            mcand <= mcand << 1;
            acc   <= acc >> 1;
          end
          cnt <= cnt - SHW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu at WIDTH=8 with hand-computed expected results.
module tb_multicycle_alu;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] op = 4'd0;
  logic [7:0] a = 8'd0, b = 8'd0;
  logic       ready, done, ovf, take_branch;
  logic [7:0] f;
  int tests = 0, fails = 0;

  multicycle_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .ready(ready), .done(done), .f(f), .ovf(ovf), .take_branch(take_branch)
  );

  always #5 clk = ~clk;

  // Presents an op at the falling edge, returns 1ns after the accepting edge E0.
  task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    tests++; if ({f, ovf, take_branch, done, ready} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      fails++; $display("FAIL reset_state got f=%h ovf=%b tb=%b done=%b ready=%b want 00 0 0 0 1",
                        f, ovf, take_branch, done, ready); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_add_sub;
    issue(4'b0000, 8'hF0, 8'h20);
    tests++; if ({done, ready, f, ovf} !== {1'b1, 1'b1, 8'h10, 1'b1}) begin
      fails++; $display("FAIL add_carry got done=%b ready=%b f=%h ovf=%b want 1 1 10 1", done, ready, f, ovf); end
    issue(4'b0001, 8'h05, 8'h07);
    tests++; if ({done, f, ovf} !== {1'b1, 8'hFE, 1'b1}) begin
      fails++; $display("FAIL sub_borrow got done=%b f=%h ovf=%b want 1 fe 1", done, f, ovf); end
  endtask

  task automatic test_shift;
    issue(4'b0110, 8'h80, 8'h03);
    tests++; if ({ready, done} !== 2'b00) begin
      fails++; $display("FAIL sra_busy1 got ready=%b done=%b want 0 0", ready, done); end
    // Stray request while busy must be dropped.
    @(negedge clk); start = 1'b1; op = 4'b0000; a = 8'hFF; b = 8'hFF;
    @(posedge clk); #1; start = 1'b0;
    tests++; if ({ready, done} !== 2'b00) begin
      fails++; $display("FAIL sra_busy2 got ready=%b done=%b want 0 0", ready, done); end
    @(posedge clk); #1;
    tests++; if ({done, ready, f, ovf} !== {1'b1, 1'b1, 8'hF0, 1'b0}) begin
      fails++; $display("FAIL sra_result got done=%b ready=%b f=%h ovf=%b want 1 1 f0 0", done, ready, f, ovf); end
    @(posedge clk); #1;
    tests++; if ({done, ready, f} !== {1'b0, 1'b1, 8'hF0}) begin
      fails++; $display("FAIL sra_hold got done=%b ready=%b f=%h want 0 1 f0", done, ready, f); end
    issue(4'b0111, 8'h81, 8'h01);
    tests++; if ({done, ready, f, ovf} !== {1'b1, 1'b1, 8'h02, 1'b0}) begin
      fails++; $display("FAIL sll1 got done=%b ready=%b f=%h ovf=%b want 1 1 02 0", done, ready, f, ovf); end
  endtask

  task automatic run_mul(input logic [7:0] x, input logic [7:0] y, input logic [7:0] ef,
                         input logic eo, input string name);
    int n;
    logic busy_ok;
    issue(4'b1010, x, y);
    n = 1; busy_ok = 1'b1;
    while (!done && n < 20) begin
      if (ready) busy_ok = 1'b0;
      @(posedge clk); #1; n++;
    end
    tests++; if (n !== 8 || !busy_ok || !ready) begin
      fails++; $display("FAIL %s_latency got cycles=%0d busy_ok=%b ready=%b want 8 1 1", name, n, busy_ok, ready); end
    tests++; if ({f, ovf} !== {ef, eo}) begin
      fails++; $display("FAIL %s_result got f=%h ovf=%b want %h %b", name, f, ovf, ef, eo); end
  endtask

  task automatic test_mul;
    run_mul(8'h0F, 8'h03, 8'h2D, 1'b0, "mul_small");
    run_mul(8'h10, 8'h10, 8'h00, 1'b1, "mul_ovf");
  endtask

  task automatic test_branch;
    issue(4'b1000, 8'h5A, 8'h5A);
    tests++; if ({done, take_branch, f, ovf} !== {1'b1, 1'b1, 8'h01, 1'b0}) begin
      fails++; $display("FAIL beq got done=%b tb=%b f=%h ovf=%b want 1 1 01 0", done, take_branch, f, ovf); end
    issue(4'b1001, 8'h5A, 8'h5A);
    tests++; if ({done, take_branch, f, ovf} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      fails++; $display("FAIL bne got done=%b tb=%b f=%h ovf=%b want 1 0 00 0", done, take_branch, f, ovf); end
  endtask

  task automatic test_back_to_back;
    issue(4'b0000, 8'h01, 8'h02);
    start = 1'b1; op = 4'b0011; a = 8'hF0; b = 8'h3C;
    tests++; if ({done, f, ovf} !== {1'b1, 8'h03, 1'b0}) begin
      fails++; $display("FAIL b2b_first got done=%b f=%h ovf=%b want 1 03 0", done, f, ovf); end
    @(posedge clk); #1; start = 1'b0;
    tests++; if ({done, ready, f} !== {1'b1, 1'b1, 8'h30}) begin
      fails++; $display("FAIL b2b_second got done=%b ready=%b f=%h want 1 1 30", done, ready, f); end
    @(posedge clk); #1;
    tests++; if (done !== 1'b0) begin
      fails++; $display("FAIL b2b_idle got done=%b want 0", done); end
  endtask

  task automatic test_reset_abort;
    logic saw_done;
    issue(4'b1010, 8'h0F, 8'h03);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests++; if ({f, ovf, take_branch, done, ready} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      fails++; $display("FAIL abort_reset got f=%h ovf=%b tb=%b done=%b ready=%b want 00 0 0 0 1",
                        f, ovf, take_branch, done, ready); end
    saw_done = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
      if (rst) begin @(negedge clk); rst = 1'b0; end
    end
    tests++; if (saw_done !== 1'b0 || ready !== 1'b1) begin
      fails++; $display("FAIL abort_no_done got saw_done=%b ready=%b want 0 1", saw_done, ready); end
    issue(4'b0101, 8'hAA, 8'hFF);
    tests++; if ({done, ready, f, ovf} !== {1'b1, 1'b1, 8'h55, 1'b0}) begin
      fails++; $display("FAIL xor_after_reset got done=%b ready=%b f=%h ovf=%b want 1 1 55 0", done, ready, f, ovf); end
  endtask

  initial begin
    test_reset;
    test_add_sub;
    test_shift;
    test_mul;
    test_branch;
    test_back_to_back;
    test_reset_abort;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got still running want finished");
    $fatal(1, "timeout");
  end
endmodule
